aiken2421_rx: RTL
=================

// Module: aiken2421_rx
// PURPOSE
//   Receive end of the BCD->2421 (Aiken) digit link: accepts a stream of 4-bit 2421 codes,
//   decodes each to BCD, rejects illegal codes, and checks the stream counts 0..9 wrapping.
//   Sits after the BCD counter/encoder; drives decoded digits to display/checker logic.
// PARAMETERS
//   CNT_W     8  width of accepted-digit counter digit_cnt
//   RESYNC_N  2  consecutive in-sequence digits required to (re)enter LOCK; legal 1..7
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous, active-low reset
//   in_code    in   4      2421-coded digit
//   in_valid   in   1      in_code valid this cycle
//   in_ready   out  1      block can accept in_code this cycle
//   bcd_out    out  4      decoded BCD digit (0..9)
//   out_valid  out  1      bcd_out valid
//   out_ready  in   1      downstream accepts bcd_out
//   code_err   out  1      1-cycle pulse: illegal code consumed
//   seq_err    out  1      1-cycle pulse: out-of-sequence digit while LOCK
//   locked     out  1      state == LOCK
//   digit_cnt  out  CNT_W  count of legal digits accepted, wraps mod 2^CNT_W
// BEHAVIOUR
//   - One clock, reset asynchronous and active-low. Reset: bcd_out=0, out_valid=0, code_err=0,
//     seq_err=0, locked=0, digit_cnt=0, state=HUNT, expected=0, good=0. in_ready=1 after reset.
//   - Accept = in_valid & in_ready. in_ready = ~out_valid | out_ready (single output register,
//     no combinational in->out path except this ready term).
//   - Legal codes: 0000=0 0001=1 0010=2 0011=3 0100=4 1011=5 1100=6 1101=7 1110=8 1111=9.
//     0101..1010 illegal.
//   - Latency: legal digit accepted in cycle N -> bcd_out/out_valid registered at N+1.
//     out_valid stays high and bcd_out stable until out_valid & out_ready.
//   - Illegal code accepted: consumed, no out_valid, code_err pulses at N+1, digit_cnt unchanged,
//     state->HUNT, good=0 (from any state).
//   - Legal digit d accepted: digit_cnt+=1 (wrap), then per state:
//     HUNT : expected=(d+1) mod 10, good=1; -> LOCK if RESYNC_N==1 else SLIP.
//     SLIP : d==expected -> good+=1, -> LOCK when good reaches RESYNC_N;
//            d!=expected -> good=1, stay SLIP, no seq_err. expected=(d+1) mod 10 always.
//     LOCK : d==expected -> stay; d!=expected -> seq_err pulse, -> SLIP, good=1
//            (SLIP, not HUNT, if RESYNC_N>1; LOCK again if RESYNC_N==1).
//   - Out-of-sequence digits are still delivered downstream; checking never blocks data.
//   - Wrap: expected after 9 is 0. digit_cnt wraps all-ones -> 0 without flag.
//   - Simultaneous output drain and new accept in same cycle: new digit loaded, no bubble.
//   - Reset mid-operation: pending output discarded, all state cleared immediately.
//   - code_err/seq_err are registered pulses, never both high in one cycle.
// STRUCTURE
//   Package aiken2421_pkg: state enum {HUNT, SLIP, LOCK} (2-bit), 2421 code constants
//   C2421_0..C2421_9, function next_digit(d) mod 10.
//   Sub-module aiken2421_decode: combinational, in_code -> {legal, bcd[3:0]}.
//   Top: handshake/output register, sequence FSM, good counter ($clog2(RESYNC_N+1)), digit_cnt.
// TESTING
//   1 Reset: drive rst_n=0 mid-stream with out_valid=1 -> all outputs 0 asynchronously, HUNT.
//   2 out_ready=1, codes 0000,0001,...,1111,0000 back-to-back -> bcd_out 0..9,0 each one cycle
//     later, locked=1 from cycle after 2nd accept, seq_err never, digit_cnt=11.
//   3 In LOCK send 0110 -> code_err one pulse, no out_valid, locked=0, digit_cnt unchanged.
//   4 In LOCK send 0011 then 1011 (3 then 5) -> bcd_out 5 delivered, seq_err pulse, locked=0;
//     then 1100,1101 (6,7) -> locked=1 after 6 accepted (good=2).
//   5 Backpressure: out_ready=0 after digit 4 -> in_ready=0, bcd_out held 4; release with
//     in_valid held on 1011 -> 4 then 5, no loss or duplication.
//   6 Feed 256 legal in-sequence digits with CNT_W=8 -> digit_cnt wraps to 0, no error pulse.

Source files
------------

// File: rtl/aiken2421_pkg.sv
// Shared types and constants for the 2421 (Aiken) digit receiver.
package aiken2421_pkg;

  // Sequence-checker states: searching, regaining lock, locked.
  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SLIP = 2'd1,
    LOCK = 2'd2
  } state_e;

  // 2421 code words for decimal digits 0..9.
  localparam logic [3:0] C2421_0 = 4'b0000;
  localparam logic [3:0] C2421_1 = 4'b0001;
  localparam logic [3:0] C2421_2 = 4'b0010;
  localparam logic [3:0] C2421_3 = 4'b0011;
  localparam logic [3:0] C2421_4 = 4'b0100;
  localparam logic [3:0] C2421_5 = 4'b1011;
  localparam logic [3:0] C2421_6 = 4'b1100;
  localparam logic [3:0] C2421_7 = 4'b1101;
  localparam logic [3:0] C2421_8 = 4'b1110;
  localparam logic [3:0] C2421_9 = 4'b1111;

  // Successor digit in a 0..9 counting stream; 9 wraps to 0.
  function automatic logic [3:0] next_digit(input logic [3:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/aiken2421_decode.sv
// Combinational 2421 -> BCD decoder with illegal-code detection.
module aiken2421_decode
  import aiken2421_pkg::*;
(
  input  logic [3:0] code_i,
  output logic       legal_o,
  output logic [3:0] bcd_o
);

  // Map each legal code word to its digit; 0101..1010 flag as illegal.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned; a missing default here would infer a latch.
    legal_o = 1'b1;
    bcd_o   = 4'd0;
    unique case (code_i)
      C2421_0: bcd_o = 4'd0;
      C2421_1: bcd_o = 4'd1;
      C2421_2: bcd_o = 4'd2;
      C2421_3: bcd_o = 4'd3;
      C2421_4: bcd_o = 4'd4;
      C2421_5: bcd_o = 4'd5;
      C2421_6: bcd_o = 4'd6;
      C2421_7: bcd_o = 4'd7;
      C2421_8: bcd_o = 4'd8;
      C2421_9: bcd_o = 4'd9;
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/aiken2421_rx.sv
// Receive end of the BCD->2421 link: decodes a handshaked stream of 2421
// codes to BCD, flags illegal codes and checks the stream counts 0..9.
module aiken2421_rx
  import aiken2421_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int RESYNC_N = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       in_code,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       bcd_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             code_err,
  output logic             seq_err,
  output logic             locked,
  output logic [CNT_W-1:0] digit_cnt
);

  localparam int GOOD_W = $clog2(RESYNC_N + 1);
  localparam logic [GOOD_W-1:0] GOOD_ONE = GOOD_W'(1);
  localparam logic [GOOD_W-1:0] GOOD_TGT = GOOD_W'(RESYNC_N);

  logic             dec_legal;
  logic [3:0]       dec_bcd;
  logic             accept;

  logic [3:0]       bcd_q, bcd_d;
  logic             out_valid_q, out_valid_d;
  logic             code_err_q, code_err_d;
  logic             seq_err_q, seq_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           state_q, state_d;
  logic [3:0]       exp_q, exp_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [GOOD_W-1:0] good_inc;

  aiken2421_decode u_decode (
    .code_i  (in_code),
    .legal_o (dec_legal),
    .bcd_o   (dec_bcd)
  );

  // Single output register: accept whenever it is empty or draining this cycle.
  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  // Output register, error pulse and digit counter next-state.
  always_comb begin
    bcd_d       = bcd_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    code_err_d  = accept & ~dec_legal;
    if (accept && dec_legal) begin
      bcd_d       = dec_bcd;
      out_valid_d = 1'b1;
      cnt_d       = cnt_q + CNT_W'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Sequence checker next-state: tracks expected digit and in-sequence run.
  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    good_d    = good_q;
    seq_err_d = 1'b0;
    good_inc  = good_q + GOOD_ONE;
    if (accept) begin
      if (!dec_legal) begin
        state_d = HUNT;
        good_d  = '0;
      end else begin
        exp_d = next_digit(dec_bcd);
        unique case (state_q)
          HUNT: begin
            good_d  = GOOD_ONE;
            state_d = (GOOD_ONE >= GOOD_TGT) ? LOCK : SLIP;
          end
          SLIP: begin
            good_d  = (dec_bcd == exp_q) ? good_inc : GOOD_ONE;
            state_d = (good_d >= GOOD_TGT) ? LOCK : SLIP;
          end
          LOCK: begin
            if (dec_bcd != exp_q) begin
              seq_err_d = 1'b1;
              good_d    = GOOD_ONE;
              state_d   = (GOOD_ONE >= GOOD_TGT) ? LOCK : SLIP;
            end
          end
          default: begin
            state_d = HUNT;
            good_d  = '0;
          end
        endcase
      end
    end
  end

  // All state registers; reset discards any pending output immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q       <= 4'd0;
      out_valid_q <= 1'b0;
      code_err_q  <= 1'b0;
      seq_err_q   <= 1'b0;
      cnt_q       <= '0;
      state_q     <= HUNT;
      exp_q       <= 4'd0;
      good_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      bcd_q       <= bcd_d;
      out_valid_q <= out_valid_d;
      code_err_q  <= code_err_d;
      seq_err_q   <= seq_err_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      exp_q       <= exp_d;
      good_q      <= good_d;
    end
  end

  assign bcd_out   = bcd_q;
  assign out_valid = out_valid_q;
  assign code_err  = code_err_q;
  assign seq_err   = seq_err_q;
  assign locked    = (state_q == LOCK);
  assign digit_cnt = cnt_q;

endmodule
